pipeline_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage 64-bit RISC-V pipeline. It detects load-use hazards between IF/ID and ID/EX and squashes younger instructions on a taken branch resolved in EX/MEM. It also sequences multi-cycle data-memory accesses issued from EX/MEM over a req/ready handshake, with a timeout fault and saturating performance counters. It drives the write-enable and flush inputs of the PC and all pipeline registers.

---
 rtl/riscv_pipe_pkg.sv | 14 +
 rtl/pipeline_ctrl_if.sv | 46 ++++
 rtl/pipeline_ctrl_hazard_detect.sv | 15 +
 rtl/pipeline_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types and defaults for the 5-stage RISC-V pipeline control logic.
package riscv_pipe_pkg;

  localparam int unsigned REG_IDX_W       = 5;
  localparam int unsigned DEFAULT_TIMEOUT = 16;
  localparam int unsigned DEFAULT_CNT_W   = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side hazard inputs and stall/flush/dmem control outputs of pipeline_ctrl.
interface pipeline_ctrl_if
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) ();

  logic [REG_IDX_W-1:0] IF_ID_Rs1;
  logic [REG_IDX_W-1:0] IF_ID_Rs2;
  logic                 ID_EX_MemRead;
  logic [REG_IDX_W-1:0] ID_EX_Rd;
  logic                 EX_MEM_Branch;
  logic                 EX_MEM_zero;
  logic                 EX_MEM_MemRead;
  logic                 EX_MEM_MemWrite;
  logic                 dmem_ready;

  logic                 dmem_req;
  logic                 PCSrc;
  logic                 PC_write;
  logic                 IF_ID_write;
  logic                 pipe_hold;
  logic                 IF_ID_flush;
  logic                 ID_EX_flush;
  logic                 EX_MEM_flush;
  logic                 dmem_timeout;
  logic [CNT_W-1:0]     stall_cycles;
  logic [CNT_W-1:0]     flush_count;

  modport master (
    output IF_ID_Rs1, IF_ID_Rs2, ID_EX_MemRead, ID_EX_Rd,
           EX_MEM_Branch, EX_MEM_zero, EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready,
    input  dmem_req, PCSrc, PC_write, IF_ID_write, pipe_hold,
           IF_ID_flush, ID_EX_flush, EX_MEM_flush, dmem_timeout,
           stall_cycles, flush_count
  );

  modport slave (
    input  IF_ID_Rs1, IF_ID_Rs2, ID_EX_MemRead, ID_EX_Rd,
           EX_MEM_Branch, EX_MEM_zero, EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready,
    output dmem_req, PCSrc, PC_write, IF_ID_write, pipe_hold,
           IF_ID_flush, ID_EX_flush, EX_MEM_flush, dmem_timeout,
           stall_cycles, flush_count
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use comparator: load in EX writing a register read by the instruction in ID.
module hazard_detect
  import riscv_pipe_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1_i,
  input  logic [REG_IDX_W-1:0] rs2_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  input  logic                 mem_read_i,
  output logic                 hazard_o
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard_o = mem_read_i && (rd_i != '0) && ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: load-use bubbles, taken-branch squash, multi-cycle dmem sequencing
// with timeout fault, and saturating stall/flush performance counters.
module pipeline_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input logic            clk,
  input logic            reset,
  pipeline_ctrl_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic acc, taken, load_use;
  logic pc_write, if_id_write, pipe_hold, pc_src;
  logic if_id_flush, id_ex_flush, ex_mem_flush, dmem_req;
  logic stall_inc, flush_inc;

  hazard_detect u_hazard_detect (
    .rs1_i      (bus.IF_ID_Rs1),
    .rs2_i      (bus.IF_ID_Rs2),
    .rd_i       (bus.ID_EX_Rd),
    .mem_read_i (bus.ID_EX_MemRead),
    .hazard_o   (load_use)
  );

  assign acc   = bus.EX_MEM_MemRead | bus.EX_MEM_MemWrite;
  assign taken = bus.EX_MEM_Branch & bus.EX_MEM_zero;

  // Next-state and control outputs; priority FAULT > memory stall > branch > load-use.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    pipe_hold    = 1'b0;
    pc_src       = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    dmem_req     = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    case (state_q)
      FAULT: begin
        pipe_hold   = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        stall_inc   = 1'b1;
      end
      default: begin
        dmem_req = acc;
        if (acc && !bus.dmem_ready) begin
          pipe_hold   = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          stall_inc   = 1'b1;
          if (state_q == RUN) begin
            state_d = MEM_WAIT;
            wait_d  = WAIT_W'(1);
          end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            state_d = FAULT;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else begin
          if (state_q == MEM_WAIT) begin
            state_d = RUN;
            wait_d  = '0;
          end
          // The release cycle advances the pipe, so a held load-use must bubble here.
          if (taken) begin
            pc_src       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            flush_inc    = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
          end
        end
      end
    endcase

    if (reset) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      pipe_hold    = 1'b0;
      pc_src       = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      dmem_req     = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
    if (flush_inc && (flush_q != {CNT_W{1'b1}})) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.dmem_req     = dmem_req;
  assign bus.PCSrc        = pc_src;
  assign bus.PC_write     = pc_write;
  assign bus.IF_ID_write  = if_id_write;
  assign bus.pipe_hold    = pipe_hold;
  assign bus.IF_ID_flush  = if_id_flush;
  assign bus.ID_EX_flush  = id_ex_flush;
  assign bus.EX_MEM_flush = ex_mem_flush;
  assign bus.dmem_timeout = (state_q == FAULT) && !reset;
  assign bus.stall_cycles = reset ? '0 : stall_q;
  assign bus.flush_count  = reset ? '0 : flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl with TIMEOUT=4, CNT_W=4: directed per-cycle vectors.
module tb_pipeline_ctrl;
  import riscv_pipe_pkg::*;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic          pcw, ifw, hold, pcsrc, fif, fid, fex, req, to;
    logic [CW-1:0] sc, fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   vec   = 0;

  function automatic exp_t mk(logic pcw, logic ifw, logic hold, logic pcsrc, logic fif,
                              logic fid, logic fex, logic req, logic to, int sc, int fc);
    exp_t e;
    e.pcw = pcw; e.ifw = ifw; e.hold = hold; e.pcsrc = pcsrc;
    e.fif = fif; e.fid = fid; e.fex = fex; e.req = req; e.to = to;
    e.sc = CW'(sc); e.fc = CW'(fc);
    return e;
  endfunction

  function automatic exp_t e_idle(logic req, int sc, int fc);
    return mk(1, 1, 0, 0, 0, 0, 0, req, 0, sc, fc);
  endfunction
  function automatic exp_t e_lu(logic req, int sc, int fc);
    return mk(0, 0, 0, 0, 0, 1, 0, req, 0, sc, fc);
  endfunction
  function automatic exp_t e_br(int sc, int fc);
    return mk(1, 1, 0, 1, 1, 1, 1, 0, 0, sc, fc);
  endfunction
  function automatic exp_t e_hold(int sc, int fc);
    return mk(0, 0, 1, 0, 0, 0, 0, 1, 0, sc, fc);
  endfunction
  function automatic exp_t e_fault(int sc, int fc);
    return mk(0, 0, 1, 0, 0, 0, 0, 0, 1, sc, fc);
  endfunction

  // Drive one cycle of inputs just after the edge and queue the response expected in that cycle.
  task automatic v(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                   input logic [4:0] rd, input logic mr, input logic br, input logic z,
                   input logic exr, input logic exw, input logic rdy, input exp_t e);
    @(posedge clk);
    #1;
    reset               = rst;
    bus.IF_ID_Rs1       = rs1;
    bus.IF_ID_Rs2       = rs2;
    bus.ID_EX_Rd        = rd;
    bus.ID_EX_MemRead   = mr;
    bus.EX_MEM_Branch   = br;
    bus.EX_MEM_zero     = z;
    bus.EX_MEM_MemRead  = exr;
    bus.EX_MEM_MemWrite = exw;
    bus.dmem_ready      = rdy;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every presented cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, g;
      e = exp_q.pop_front();
      g.pcw = bus.PC_write; g.ifw = bus.IF_ID_write; g.hold = bus.pipe_hold;
      g.pcsrc = bus.PCSrc; g.fif = bus.IF_ID_flush; g.fid = bus.ID_EX_flush;
      g.fex = bus.EX_MEM_flush; g.req = bus.dmem_req; g.to = bus.dmem_timeout;
      g.sc = bus.stall_cycles; g.fc = bus.flush_count;
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL vec%0d pcw,ifw,hold,pcsrc,fif,fid,fex,req,to got=%b required=%b stall got=%0d required=%0d flush got=%0d required=%0d",
                 vec, g[2*CW+8:2*CW], e[2*CW+8:2*CW], g.sc, e.sc, g.fc, e.fc);
      end
      vec++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.IF_ID_Rs1 = '0; bus.IF_ID_Rs2 = '0; bus.ID_EX_Rd = '0; bus.ID_EX_MemRead = 1'b0;
    bus.EX_MEM_Branch = 1'b0; bus.EX_MEM_zero = 1'b0; bus.EX_MEM_MemRead = 1'b0;
    bus.EX_MEM_MemWrite = 1'b0; bus.dmem_ready = 1'b0;

    // Reset: idle outputs, dmem_req masked even with an access present.
    v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_idle(0, 0, 0));
    v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, e_idle(0, 0, 0));
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_idle(0, 0, 0));
    // Load-use on Rs2, then Rd=0 and non-load variants.
    v(0, 0, 5, 5, 1, 0, 0, 0, 0, 0, e_lu(0, 0, 0));
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_idle(0, 1, 0));
    v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, e_idle(0, 1, 0));
    v(0, 5, 0, 5, 0, 0, 0, 0, 0, 0, e_idle(0, 1, 0));
    // Taken branch, not-taken branch, branch masking a load-use.
    v(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, e_br(1, 0));
    v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, e_idle(0, 1, 1));
    v(0, 0, 5, 5, 1, 1, 1, 0, 0, 0, e_br(1, 1));
    // Load with 3 not-ready cycles, then zero-wait write.
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, e_hold(1, 2));
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, e_hold(2, 2));
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, e_hold(3, 2));
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, e_idle(1, 4, 2));
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_idle(0, 4, 2));
    v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, e_idle(1, 4, 2));
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e_idle(0, 4, 2));
    // Load-use under memory stall: held, then one bubble on release.
    v(0, 7, 0, 7, 1, 0, 0, 1, 0, 0, e_hold(4, 2));
    v(0, 7, 0, 7, 1, 0, 0, 1, 0, 0, e_hold(5, 2));
    v(0, 7, 0, 7, 1, 0, 0, 1, 0, 1, e_lu(1, 6, 2));
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_idle(0, 7, 2));
    // Reset in MEM_WAIT.
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, e_hold(7, 2));
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, e_hold(8, 2));
    v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, e_idle(0, 0, 0));
    // Back in RUN: full TIMEOUT window of not-ready, then sticky FAULT with saturating stalls.
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, e_hold(0, 0));
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, e_hold(1, 0));
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, e_hold(2, 0));
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, e_hold(3, 0));
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, e_fault(4, 0));
    v(0, 0, 0, 0, 0, 1, 1, 1, 0, 1, e_fault(5, 0));
    for (int k = 6; k <= 18; k++) begin
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_fault((k > 15) ? 15 : k, 0));
    end
    // Reset clears the fault; controller runs normally afterwards.
    v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_idle(0, 0, 0));
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_idle(0, 0, 0));
    v(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, e_br(0, 0));
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_idle(0, 0, 1));

    @(posedge clk);
    @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
